// File: rtl/ctrl_pkg.sv
// Shared definitions for the issue stage: opcode/funct constants, ALUOp[2:0] codes,
// PCSrc/RegDst/MemtoReg codes and the ID/EX control bundle type.
package ctrl_pkg;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpMul   = 6'h1c;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  // R-type functs, instruction[5:0]
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluR   = 3'b010,
    AluAnd = 3'b100,
    AluSlt = 3'b101,
    AluMul = 3'b110
  } aluop_e;

  typedef enum logic [1:0] {
    PcNext = 2'b00,
    PcJump = 2'b01,
    PcReg  = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    DstRt = 2'b00,
    DstRd = 2'b01,
    DstRa = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00,
    WbMem = 2'b01,
    WbPc  = 2'b10
  } memtoreg_e;

  typedef struct packed {
    pcsrc_e     pcsrc;
    logic       branch;
    logic       regwrite;
    regdst_e    regdst;
    logic       memread;
    logic       memwrite;
    memtoreg_e  memtoreg;
    logic       alusrc1;
    logic       alusrc2;
    logic       extop;
    logic       luop;
    logic [3:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decoder.
// Ports:
//   opcode  in  6  instruction[31:26]
//   funct   in  6  instruction[5:0]
//   ctrl    out    decoded control bundle (all zero when illegal)
//   illegal out 1  opcode/funct not decodable
// EN_EXT = 0 makes bne and jalr illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned EN_EXT = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  aluop_e alu;

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    alu     = AluAdd;
    unique case (opcode)
      OpRtype: begin
        alu = AluR;
        unique case (funct)
          FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor, FnSlt, FnSltu: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = DstRd;
          end
          FnSll, FnSrl, FnSra: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = DstRd;
            ctrl.alusrc1  = 1'b1;
          end
          FnJr: ctrl.pcsrc = PcReg;
          FnJalr: begin
            if (EN_EXT != 0) begin
              ctrl.pcsrc    = PcReg;
              ctrl.regwrite = 1'b1;
              ctrl.regdst   = DstRd;
              ctrl.memtoreg = WbPc;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OpLw: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = WbMem;
        ctrl.alusrc2  = 1'b1;
      end
      OpSw: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc2  = 1'b1;
      end
      OpLui: begin
        ctrl.regwrite = 1'b1;
        ctrl.luop     = 1'b1;
        ctrl.alusrc2  = 1'b1;
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc2  = 1'b1;
        ctrl.extop    = 1'b1;
        if (opcode == OpSlti || opcode == OpSltiu) alu = AluSlt;
      end
      OpAndi: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc2  = 1'b1;
        alu           = AluAnd;
      end
      OpBeq: begin
        ctrl.branch = 1'b1;
        alu         = AluSub;
      end
      OpBne: begin
        if (EN_EXT != 0) begin
          ctrl.branch = 1'b1;
          alu         = AluSub;
        end else begin
          illegal = 1'b1;
        end
      end
      OpJ: ctrl.pcsrc = PcJump;
      OpJal: begin
        ctrl.pcsrc    = PcJump;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = DstRa;
        ctrl.memtoreg = WbPc;
      end
      OpMul: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = DstRd;
        alu           = AluMul;
      end
      default: illegal = 1'b1;
    endcase
    ctrl.aluop = {opcode[0], alu};
    // An illegal instruction still issues, but must not cause any side effect.
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/ctrl_issue_stage.sv
// ID/EX issue stage: decodes the IF/ID instruction, registers the control bundle
// and holds issue while a multi-cycle mul occupies the slot.
// Ports:
//   clk, reset (async, active-high)
//   in_valid, opcode[5:0], funct[5:0]  instruction offered by IF/ID
//   stall_in  hold ID/EX;  flush  kill ID/EX (wins over everything)
//   in_ready  instruction taken when in_valid && in_ready
//   ex_valid, ex_illegal, ex_* bundle  registered ID/EX contents
//   mul_busy  multiplier occupancy is blocking issue
module ctrl_issue_stage
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned EN_EXT  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       stall_in,
  input  logic       flush,
  output logic       in_ready,
  output logic       ex_valid,
  output logic [1:0] ex_pcsrc,
  output logic       ex_branch,
  output logic       ex_regwrite,
  output logic [1:0] ex_regdst,
  output logic       ex_memread,
  output logic       ex_memwrite,
  output logic [1:0] ex_memtoreg,
  output logic       ex_alusrc1,
  output logic       ex_alusrc2,
  output logic       ex_extop,
  output logic       ex_luop,
  output logic [3:0] ex_aluop,
  output logic       ex_illegal,
  output logic       mul_busy
);

  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);
  localparam bit MulMulti = (MUL_LAT > 1);

  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  ctrl_t           ex_d, ex_q;
  logic            valid_d, valid_q;
  logic            illegal_d, illegal_q;
  logic [CntW-1:0] mul_cnt_d, mul_cnt_q;
  logic            accept;

  ctrl_decode #(
    .EN_EXT(EN_EXT)
  ) u_decode (
    .opcode (opcode),
    .funct  (funct),
    .ctrl   (dec_ctrl),
    .illegal(dec_illegal)
  );

  assign mul_busy = (mul_cnt_q != '0);
  assign in_ready = !stall_in && !mul_busy;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ex_d      = ex_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush || !stall_in) begin
      // Flush discards anything accepted this cycle; otherwise no accept means bubble.
      ex_d      = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      if (!flush && accept) begin
        ex_d      = dec_ctrl;
        valid_d   = 1'b1;
        illegal_d = dec_illegal;
      end
    end
  end

  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (flush) begin
      mul_cnt_d = '0;
    end else if (MulMulti && accept && opcode == OpMul) begin
      mul_cnt_d = MulLoad;
    end else if (mul_busy) begin
      // Counts down even while stalled.
      mul_cnt_d = mul_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q      <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      mul_cnt_q <= '0;
    end else begin
      ex_q      <= ex_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_illegal  = illegal_q;
  assign ex_pcsrc    = ex_q.pcsrc;
  assign ex_branch   = ex_q.branch;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_regdst   = ex_q.regdst;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc1  = ex_q.alusrc1;
  assign ex_alusrc2  = ex_q.alusrc2;
  assign ex_extop    = ex_q.extop;
  assign ex_luop     = ex_q.luop;
  assign ex_aluop    = ex_q.aluop;

endmodule

// File: tb/tb_ctrl_issue_stage.sv
// Bench for ctrl_issue_stage: two instances share stimulus
// (index 0: MUL_LAT=4, EN_EXT=1; index 1: MUL_LAT=1, EN_EXT=0), each tracked by its own
// behavioural model of the issue slot.
module tb_ctrl_issue_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, stall_in, flush;
  logic [5:0] opcode, funct;

  logic [1:0] in_ready, ex_valid, ex_illegal, mul_busy;
  logic [1:0] ex_branch, ex_regwrite, ex_memread, ex_memwrite;
  logic [1:0] ex_alusrc1, ex_alusrc2, ex_extop, ex_luop;
  logic [1:0] ex_pcsrc[2];
  logic [1:0] ex_regdst[2];
  logic [1:0] ex_memtoreg[2];
  logic [3:0] ex_aluop[2];

  int checks = 0;
  int failures = 0;

  // Model state per instance
  logic [17:0] m_bundle[2];
  logic        m_valid[2];
  logic        m_ill[2];
  int          m_busy[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_issue_stage #(
      .MUL_LAT(g == 0 ? 4 : 1),
      .EN_EXT (g == 0 ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .opcode     (opcode),
      .funct      (funct),
      .stall_in   (stall_in),
      .flush      (flush),
      .in_ready   (in_ready[g]),
      .ex_valid   (ex_valid[g]),
      .ex_pcsrc   (ex_pcsrc[g]),
      .ex_branch  (ex_branch[g]),
      .ex_regwrite(ex_regwrite[g]),
      .ex_regdst  (ex_regdst[g]),
      .ex_memread (ex_memread[g]),
      .ex_memwrite(ex_memwrite[g]),
      .ex_memtoreg(ex_memtoreg[g]),
      .ex_alusrc1 (ex_alusrc1[g]),
      .ex_alusrc2 (ex_alusrc2[g]),
      .ex_extop   (ex_extop[g]),
      .ex_luop    (ex_luop[g]),
      .ex_aluop   (ex_aluop[g]),
      .ex_illegal (ex_illegal[g]),
      .mul_busy   (mul_busy[g])
    );
  end

  function automatic int lat(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic bit ext(int k);
    return (k == 0);
  endfunction

  function automatic logic [17:0] got_bundle(int k);
    return {ex_pcsrc[k], ex_branch[k], ex_regwrite[k], ex_regdst[k], ex_memread[k],
            ex_memwrite[k], ex_memtoreg[k], ex_alusrc1[k], ex_alusrc2[k], ex_extop[k],
            ex_luop[k], ex_aluop[k]};
  endfunction

  // Reference decode from the instruction table; returns zero bundle when illegal.
  function automatic logic [17:0] ref_ctrl(input logic [5:0] op, input logic [5:0] fn,
                                           input bit en_ext, output logic ill);
    logic [1:0] pcsrc = 2'd0, regdst = 2'd0, memtoreg = 2'd0;
    logic       br = 0, rw = 0, mr = 0, mw = 0, s1 = 0, s2 = 0, ex = 0, lu = 0;
    logic [2:0] alu = 3'b000;
    ill = 1'b0;
    if (op == 6'h00) begin
      alu = 3'b010;
      if (fn inside {[6'h20:6'h27], 6'h2a, 6'h2b}) begin
        rw = 1; regdst = 2'd1;
      end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
        rw = 1; regdst = 2'd1; s1 = 1;
      end else if (fn == 6'h08) begin
        pcsrc = 2'd2;
      end else if (fn == 6'h09 && en_ext) begin
        pcsrc = 2'd2; rw = 1; regdst = 2'd1; memtoreg = 2'd2;
      end else ill = 1'b1;
    end else if (op == 6'h23) begin
      rw = 1; mr = 1; memtoreg = 2'd1; s2 = 1;
    end else if (op == 6'h2b) begin
      mw = 1; s2 = 1;
    end else if (op == 6'h0f) begin
      rw = 1; lu = 1; s2 = 1;
    end else if (op inside {6'h08, 6'h09, 6'h0a, 6'h0b}) begin
      rw = 1; s2 = 1; ex = 1;
      if (op inside {6'h0a, 6'h0b}) alu = 3'b101;
    end else if (op == 6'h0c) begin
      rw = 1; s2 = 1; alu = 3'b100;
    end else if (op == 6'h04 || (op == 6'h05 && en_ext)) begin
      br = 1; alu = 3'b001;
    end else if (op == 6'h02) begin
      pcsrc = 2'd1;
    end else if (op == 6'h03) begin
      pcsrc = 2'd1; rw = 1; regdst = 2'd2; memtoreg = 2'd2;
    end else if (op == 6'h1c) begin
      rw = 1; regdst = 2'd1; alu = 3'b110;
    end else ill = 1'b1;
    if (ill) return '0;
    return {pcsrc, br, rw, regdst, mr, mw, memtoreg, s1, s2, ex, lu, op[0], alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bundle[k] = '0; m_valid[k] = 0; m_ill[k] = 0; m_busy[k] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ex_valid%0d", k), 32'(ex_valid[k]), 32'(m_valid[k]));
      check($sformatf("ex_illegal%0d", k), 32'(ex_illegal[k]), 32'(m_ill[k]));
      check($sformatf("bundle%0d", k), 32'(got_bundle(k)), 32'(m_bundle[k]));
      check($sformatf("mul_busy%0d", k), 32'(mul_busy[k]), 32'(m_busy[k] != 0));
    end
  endtask

  // Drive one cycle of inputs (called right after a falling edge), check in_ready,
  // advance the model, then check the registered outputs at the next falling edge.
  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic st, input logic fl);
    in_valid = v; opcode = op; funct = fn; stall_in = st; flush = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic        acc, il;
      logic [17:0] b;
      check($sformatf("in_ready%0d", k), 32'(in_ready[k]), 32'(!st && m_busy[k] == 0));
      acc = v && !st && m_busy[k] == 0;
      b = ref_ctrl(op, fn, ext(k), il);
      if (fl) begin
        m_bundle[k] = '0; m_valid[k] = 0; m_ill[k] = 0; m_busy[k] = 0;
      end else begin
        if (!st) begin
          m_valid[k]  = acc;
          m_bundle[k] = acc ? b : '0;
          m_ill[k]    = acc ? il : 1'b0;
        end
        if (acc && op == 6'h1c && lat(k) > 1) m_busy[k] = lat(k) - 1;
        else if (m_busy[k] > 0) m_busy[k]--;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  logic [5:0] ops[16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09,
                          6'h0a, 6'h0b, 6'h0c, 6'h04, 6'h05, 6'h02, 6'h03, 6'h1c};
  logic [5:0] fns[8] = '{6'h20, 6'h2a, 6'h00, 6'h03, 6'h08, 6'h09, 6'h27, 6'h01};

  initial begin
    reset = 1'b1; in_valid = 0; opcode = '0; funct = '0; stall_in = 0; flush = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // lw
    step(1, 6'h23, 6'h00, 0, 0);
    check("lw_aluop", 32'(ex_aluop[0]), 32'(4'b1000));
    check("lw_memtoreg", 32'(ex_memtoreg[0]), 32'(2'b01));

    // mul holds issue for MUL_LAT-1 cycles, then add goes through
    step(1, 6'h1c, 6'h02, 0, 0);
    check("mul_aluop", 32'(ex_aluop[0]), 32'(4'b0110));
    for (int i = 0; i < 3; i++) begin
      check("mul_hold_ready", 32'(in_ready[0]), 32'(0));
      step(1, 6'h00, 6'h20, 0, 0);
    end
    step(1, 6'h00, 6'h20, 0, 0);
    check("add_after_mul", 32'({ex_valid[0], ex_regwrite[0], ex_regdst[0]}), 32'(4'b1101));

    // sw held behind stall, appears after stall falls
    step(1, 6'h2b, 6'h00, 1, 0);
    step(1, 6'h2b, 6'h00, 1, 0);
    check("stall_holds_add", 32'(ex_regwrite[0]), 32'(1));
    step(1, 6'h2b, 6'h00, 0, 0);
    check("sw_after_stall", 32'({ex_memwrite[0], ex_alusrc2[0]}), 32'(2'b11));

    // flush beats stall and accept
    step(1, 6'h00, 6'h20, 1, 1);
    check("flush_bubble", 32'({ex_valid[0], got_bundle(0)}), 32'(0));

    // bne / jalr under both EN_EXT settings
    step(1, 6'h05, 6'h00, 0, 0);
    check("bne_ext0_ill", 32'(ex_illegal[1]), 32'(1));
    check("bne_ext1", 32'({ex_branch[0], ex_aluop[0]}), 32'(5'b11001));
    step(1, 6'h00, 6'h09, 0, 0);

    // flush clears an in-flight mul
    step(1, 6'h1c, 6'h02, 0, 0);
    step(0, 6'h00, 6'h00, 0, 1);
    step(1, 6'h00, 6'h20, 0, 0);

    // reset mid-mul with 2 cycles left
    step(1, 6'h1c, 6'h02, 0, 0);
    step(1, 6'h00, 6'h20, 1, 0);
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(ex_valid[0]), 32'(0));
    check("rst_busy", 32'(mul_busy[0]), 32'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 0; stall_in = 0; flush = 0;
    #1;
    check("rst_ready", 32'(in_ready[0]), 32'(1));
    @(negedge clk);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int         oi;
      logic [5:0] op, fn;
      oi = $urandom_range(0, 17);
      op = (oi < 16) ? ops[oi] : 6'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      step($urandom_range(0, 3) != 0, op, fn, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
